// File: rtl/deparser_pkg.sv
// deparser_pkg: shared widths, access encodings, FSM states and length clamp for the deparser.
package deparser_pkg;
  localparam int MAX_HDRS = 8;
  localparam int HDR_SLOT = 64;
  localparam int LEN_W = 8;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W = $clog2(MAX_HDRS);
  localparam logic [3:0] WIDTH_BYTE = 4'b0001;
  typedef enum logic [2:0] {DP_IDLE, DP_SCAN, DP_RD, DP_LAT, DP_WR, DP_DONE} dp_state_e;
  function automatic logic [LEN_W-1:0] clamp_len(input logic [DATA_W-1:0] l);
    return (l > DATA_W'(HDR_SLOT)) ? LEN_W'(HDR_SLOT) : l[LEN_W-1:0];
  endfunction
endpackage

// File: rtl/deparser_len_tab.sv
// deparser_len_tab: per-header length register file, one write port, one combinational read port.
module deparser_len_tab
  import deparser_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [ID_W-1:0]  waddr,
  input  logic [LEN_W-1:0] wdata,
  input  logic [ID_W-1:0]  raddr,
  output logic [LEN_W-1:0] rdata
);
  logic [LEN_W-1:0] tab [MAX_HDRS];
  always_ff @(posedge clk or negedge rst)
    if (!rst) tab <= '{default: '0};
    else if (we) tab[waddr] <= wdata;
  assign rdata = tab[raddr];
endmodule

// File: rtl/deparser.sv
// deparser: copies each valid header from its PHV slot into consecutive packet bytes, one byte per read/write pair.
module deparser
  import deparser_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   pkt_addr_i,
  input  logic [ADDR_W-1:0]   phv_addr_i,
  input  logic [MAX_HDRS-1:0] hdr_valid_i,
  output logic                busy_o,
  output logic                ready_o,
  output logic [15:0]         pkt_len_o,
  output logic                mem_ce_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [3:0]          mem_width_o,
  output logic [DATA_W-1:0]   mem_data_o,
  input  logic [DATA_W-1:0]   mem_data_i,
  input  logic                dp_mod_start_i,
  input  logic [DATA_W-1:0]   dp_mod_hdr_id_i,
  input  logic [DATA_W-1:0]   dp_mod_hdr_len_i
);
  dp_state_e state, nxt;
  logic [ADDR_W-1:0] dst, phv, rd_addr;
  logic [MAX_HDRS-1:0] valid;
  logic [ID_W-1:0] id;
  logic [LEN_W-1:0] off, rem, cur_len;
  logic [15:0] pkt_len;
  logic [7:0] byte_q;
  logic hit, last, cfg_we, unused_hi;
  assign unused_hi = ^mem_data_i[DATA_W-1:8];
  assign cfg_we = state == DP_IDLE && dp_mod_start_i && dp_mod_hdr_id_i < DATA_W'(MAX_HDRS);
  deparser_len_tab u_len_tab (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_we),
    .waddr (dp_mod_hdr_id_i[ID_W-1:0]),
    .wdata (clamp_len(dp_mod_hdr_len_i)),
    .raddr (id),
    .rdata (cur_len)
  );
  assign hit = valid[id] && cur_len != '0;
  assign last = id == ID_W'(MAX_HDRS - 1);
  assign rd_addr = phv + (ADDR_W'(id) << $clog2(HDR_SLOT)) + ADDR_W'(off);
  always_comb begin
    nxt = state;
    case (state)
      DP_IDLE: nxt = start_i ? DP_SCAN : DP_IDLE;
      DP_SCAN: nxt = hit ? DP_RD : (last ? DP_DONE : DP_SCAN);
      DP_RD:   nxt = DP_LAT;
      DP_LAT:  nxt = DP_WR;
      DP_WR:   nxt = rem != LEN_W'(1) ? DP_RD : (last ? DP_DONE : DP_SCAN);
      DP_DONE: nxt = DP_IDLE;
      default: nxt = DP_IDLE;
    endcase
  end
  always_comb begin
    busy_o = state != DP_IDLE;
    ready_o = state == DP_DONE;
    mem_ce_o = state == DP_RD || state == DP_WR;
    mem_we_o = state == DP_WR;
    mem_addr_o = state == DP_WR ? dst : (state == DP_RD ? rd_addr : '0);
    mem_width_o = mem_ce_o ? WIDTH_BYTE : 4'b0000;
    mem_data_o = state == DP_WR ? {{(DATA_W-8){1'b0}}, byte_q} : '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= DP_IDLE;
      dst <= '0;
      phv <= '0;
      valid <= '0;
      id <= '0;
      off <= '0;
      rem <= '0;
      pkt_len <= '0;
      byte_q <= '0;
      pkt_len_o <= '0;
    end else begin
      state <= nxt;
      case (state)
        DP_IDLE: if (start_i) begin
          dst <= pkt_addr_i;
          phv <= phv_addr_i;
          valid <= hdr_valid_i;
          id <= '0;
          pkt_len <= '0;
        end
        DP_SCAN: if (hit) begin
          off <= '0;
          rem <= cur_len;
        end else if (!last) id <= id + ID_W'(1);
        DP_LAT: byte_q <= mem_data_i[7:0];
        DP_WR: begin
          dst <= dst + ADDR_W'(1);
          off <= off + LEN_W'(1);
          pkt_len <= pkt_len + 16'd1;
          rem <= rem - LEN_W'(1);
          if (rem == LEN_W'(1) && !last) id <= id + ID_W'(1);
        end
        DP_DONE: pkt_len_o <= pkt_len;
        default: ;
      endcase
    end
endmodule
